// File: rtl/bcout_pipe_pkg.sv
// Shared definitions for the DSP48A1 B-path transmit stage.
// Holds operand width defaults, register-stage defaults and pre-adder op decode.
package bcout_pipe_pkg;

    // Operand width of the B and D paths in the DSP48A1 slice
    localparam int B_WIDTH = 18;

    // Default register-stage enables for the B path
    localparam int B0REG_DEFAULT = 0;
    localparam int B1REG_DEFAULT = 1;

    // Pre-adder operation selected by opmode bits 4 (pre-add enable) and 6 (subtract)
    typedef enum logic [1:0] {
        PRE_PASS = 2'd0,
        PRE_ADD  = 2'd1,
        PRE_SUB  = 2'd2
    } pre_op_e;

    function automatic pre_op_e pre_op_decode(input logic preadd, input logic presub);
        pre_op_e op;
        op = PRE_PASS;
        if (preadd) begin
            op = presub ? PRE_SUB : PRE_ADD;
        end
        return op;
    endfunction

    // Any non-zero register parameter enables the stage
    function automatic int stage_en(input int reg_cfg);
        return (reg_cfg != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/bcout_pipe_reg_mux.sv
// Optional pipeline register with bypass select: sync active-high reset, clock enable.
// Ports: clk, rst, ce, d_in[WIDTH] in; q_out[WIDTH] = registered (REG!=0) or d_in (REG=0).
module bcout_pipe_reg_mux
    import bcout_pipe_pkg::*;
#(
    parameter int WIDTH = B_WIDTH,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    localparam bit REG_EN = (REG != 0);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state: load on enable, otherwise hold
    always_comb begin
        data_d = data_q;
        if (ce) begin
            data_d = d_in;
        end
    end

    // Reset wins over clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // When bypassed the flop is left unused and trimmed by synthesis
    always_comb begin
        q_out = d_in;
        if (REG_EN) begin
            q_out = data_q;
        end
    end

endmodule

// File: rtl/bcout_pipe.sv
// DSP48A1 B-path transmit stage: optional B0 register, D pre-adder/subtractor, optional B1 register.
// Ports: clk, rstb (sync, active-high), ceb, b_in, d, opmode4, opmode6 in; bcout, b1_out out.
module bcout_pipe
    import bcout_pipe_pkg::*;
#(
    parameter int WIDTH = B_WIDTH,
    parameter int B0REG = B0REG_DEFAULT,
    parameter int B1REG = B1REG_DEFAULT
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ceb,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] d,
    input  logic             opmode4,
    input  logic             opmode6,
    output logic [WIDTH-1:0] bcout,
    output logic [WIDTH-1:0] b1_out
);

    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] b1;
    pre_op_e          pre_op;

    // B0 stage: registers the selected B operand ahead of the pre-adder
    bcout_pipe_reg_mux #(
        .WIDTH (WIDTH),
        .REG   (stage_en(B0REG))
    ) u_b0 (
        .clk   (clk),
        .rst   (rstb),
        .ce    (ceb),
        .d_in  (b_in),
        .q_out (b0)
    );

    // Pre-adder: modulo-2^WIDTH, carry/borrow dropped, operands unsigned
    always_comb begin
        pre_op = pre_op_decode(opmode4, opmode6);
        pre    = b0;
        unique case (pre_op)
            PRE_ADD: pre = d + b0;
            PRE_SUB: pre = d - b0;
            default: pre = b0;
        endcase
    end

    // B1 stage: feeds both the cascade and the local multiplier
    bcout_pipe_reg_mux #(
        .WIDTH (WIDTH),
        .REG   (stage_en(B1REG))
    ) u_b1 (
        .clk   (clk),
        .rst   (rstb),
        .ce    (ceb),
        .d_in  (pre),
        .q_out (b1)
    );

    assign bcout  = b1;
    assign b1_out = b1;

endmodule
